// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 datapath slice:
//   - default data/address widths
//   - instruction opcodes (upper nibble of IR)
//   - bus-source enum used by the W-bus mux, plus its priority encoder
//   - packed 12-bit control word as issued by the controller/sequencer
// Optional feature macro used elsewhere in the slice: SAP1_BUS_CHECK_EN
// -----------------------------------------------------------------------------
package sap1_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_PC,
    SRC_RAM,
    SRC_IR,
    SRC_A,
    SRC_ALU
  } bus_src_e;

  // Control word in controller bit order, MSB first. Load/enable polarities
  // follow the classic SAP-1: LM, CE, L1, E1, LA, LB, LO are active-low.
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic l1;
    logic e1;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  // Every load/drive deasserted.
  localparam ctrl_t CTRL_IDLE = 12'b0011_1110_0011;

  // Fixed-priority bus arbitration: Ep > CE > E1 > EA > EU.
  function automatic bus_src_e bus_select(input logic ep, input logic ce_n,
                                          input logic e1_n, input logic ea,
                                          input logic eu);
    if (ep)         return SRC_PC;
    else if (!ce_n) return SRC_RAM;
    else if (!e1_n) return SRC_IR;
    else if (ea)    return SRC_A;
    else if (eu)    return SRC_ALU;
    else            return SRC_NONE;
  endfunction

  // Number of simultaneously active bus drivers (0..5).
  function automatic logic [2:0] bus_driver_count(input logic ep, input logic ce_n,
                                                  input logic e1_n, input logic ea,
                                                  input logic eu);
    return 3'(ep) + 3'(!ce_n) + 3'(!e1_n) + 3'(ea) + 3'(eu);
  endfunction

endpackage

// File: rtl/sap1_if.sv
// -----------------------------------------------------------------------------
// sap1_if
// Controller <-> datapath bundle: 12-bit control word, RAM program port and
// the datapath status/observation outputs.
//   master : controller / programmer side (drives control, reads status)
//   slave  : datapath side
// With SAP1_BUS_CHECK_EN defined, carries the sticky bus_err flag as well.
// -----------------------------------------------------------------------------
interface sap1_if
  import sap1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  // Control word
  logic Cp, Ep, LM, CE, L1, E1, LA, EA, SU, EU, LB, LO;
  // Program port
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  // Status / observation
  logic [3:0]    opcode;
  logic          halt;
  logic [DW-1:0] out_data;
  logic [DW-1:0] wbus;
`ifdef SAP1_BUS_CHECK_EN
  logic          bus_err;
`endif

  modport master (
`ifdef SAP1_BUS_CHECK_EN
    input  bus_err,
`endif
    output Cp, Ep, LM, CE, L1, E1, LA, EA, SU, EU, LB, LO,
    output prog_we, prog_addr, prog_data,
    input  opcode, halt, out_data, wbus
  );

  modport slave (
`ifdef SAP1_BUS_CHECK_EN
    output bus_err,
`endif
    input  Cp, Ep, LM, CE, L1, E1, LA, EA, SU, EU, LB, LO,
    input  prog_we, prog_addr, prog_data,
    output opcode, halt, out_data, wbus
  );

endinterface

// File: rtl/sap1_ram16x8.sv
// -----------------------------------------------------------------------------
// sap1_ram16x8
// SAP-1 program/data memory, 2**AW words of DW bits.
//   CLK    in  clock, write on posedge
//   we     in  program write strobe
//   waddr  in  program write address
//   wdata  in  program write data
//   raddr  in  read address (from MAR)
//   rdata  out asynchronous read data (gated onto the bus by CE in the top)
// A write and a read of the same address in one cycle returns the old word
// until the edge.
// -----------------------------------------------------------------------------
module sap1_ram16x8
  import sap1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: memory arrays get no reset branch; program contents must survive
  // CLR, and a reset loop would also block RAM inference.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// -----------------------------------------------------------------------------
// sap1_datapath
// SAP-1 datapath executing the controller's 12-bit control word. Holds PC,
// MAR, RAM, IR, A, B, the adder/subtractor, the output register and the
// shared W-bus. Control is sampled and registers load on posedge CLK.
//   CLK   in  clock
//   CLR   in  asynchronous active-low reset (RAM is not cleared)
//   dp    sap1_if.slave: control word, program port, opcode/halt/out_data/wbus
// Optional: SAP1_BUS_CHECK_EN adds the sticky dp.bus_err multi-driver flag.
// -----------------------------------------------------------------------------
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic  CLK,
  input logic  CLR,
  sap1_if.slave dp
);

  logic [AW-1:0] pc, mar;
  logic [DW-1:0] ir, a_reg, b_reg, out_reg;
  logic [DW-1:0] alu, ram_rd, wbus;
  logic          halt;
  bus_src_e      src;

  sap1_ram16x8 #(.DW(DW), .AW(AW)) u_ram (
    .CLK   (CLK),
    .we    (dp.prog_we),
    .waddr (dp.prog_addr),
    .wdata (dp.prog_data),
    .raddr (mar),
    .rdata (ram_rd)
  );

  assign halt = (ir[DW-1 -: 4] == OP_HLT);

  // Carry/borrow is intentionally dropped: results wrap modulo 2**DW.
  assign alu = dp.SU ? (a_reg - b_reg) : (a_reg + b_reg);

  assign src = bus_select(dp.Ep, dp.CE, dp.E1, dp.EA, dp.EU);

  // NOTE: the default before the case keeps this purely combinational; any
  // path that skipped the assignment would infer a latch.
  always_comb begin
    wbus = '0;
    case (src)
      SRC_PC:  wbus = {{(DW-AW){1'b0}}, pc};
      SRC_RAM: wbus = ram_rd;
      SRC_IR:  wbus = {{(DW-4){1'b0}}, ir[3:0]};
      SRC_A:   wbus = a_reg;
      SRC_ALU: wbus = alu;
      default: wbus = '0;
    endcase
    // Bus reads as idle while CLR is held, even if a RAM driver is enabled.
    if (!CLR) wbus = '0;
  end

  // All loads see the same pre-edge bus value, so an A load from the ALU
  // captures the result computed from the old A.
  // NOTE: non-blocking assignments give every register the pre-edge values
  // regardless of statement order.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
    end else if (!halt) begin
      if (dp.Cp)  pc      <= pc + 1'b1;
      if (!dp.LM) mar     <= wbus[AW-1:0];
      if (!dp.L1) ir      <= wbus;
      if (!dp.LA) a_reg   <= wbus;
      if (!dp.LB) b_reg   <= wbus;
      if (!dp.LO) out_reg <= wbus;
    end
  end

  assign dp.opcode   = ir[DW-1 -: 4];
  assign dp.halt     = halt;
  assign dp.out_data = out_reg;
  assign dp.wbus     = wbus;

`ifdef SAP1_BUS_CHECK_EN
  logic bus_err_q;

  // Sticky contention flag; arbitration itself is unaffected.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      bus_err_q <= 1'b0;
    end else if (bus_driver_count(dp.Ep, dp.CE, dp.E1, dp.EA, dp.EU) > 3'd1) begin
      bus_err_q <= 1'b1;
    end
  end

  assign dp.bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_sap1_datapath.sv
// -----------------------------------------------------------------------------
// tb_sap1_datapath
// Acts as SAP-1 controller: changes control on negedge CLK, observes between
// edges. Expected values come from an ISA-level model and are queued in a
// scoreboard when stimulus is driven, then popped when the DUT is observed.
// -----------------------------------------------------------------------------
module tb_sap1_datapath;
  import sap1_pkg::*;

  localparam logic [11:0] M_CP = 12'b1000_0000_0000;
  localparam logic [11:0] M_EP = 12'b0100_0000_0000;
  localparam logic [11:0] M_LM = 12'b0010_0000_0000;
  localparam logic [11:0] M_CE = 12'b0001_0000_0000;
  localparam logic [11:0] M_L1 = 12'b0000_1000_0000;
  localparam logic [11:0] M_E1 = 12'b0000_0100_0000;
  localparam logic [11:0] M_LA = 12'b0000_0010_0000;
  localparam logic [11:0] M_EA = 12'b0000_0001_0000;
  localparam logic [11:0] M_SU = 12'b0000_0000_1000;
  localparam logic [11:0] M_EU = 12'b0000_0000_0100;
  localparam logic [11:0] M_LB = 12'b0000_0000_0010;
  localparam logic [11:0] M_LO = 12'b0000_0000_0001;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  sap1_if #(.DW(8), .AW(4)) dp_if ();

  sap1_datapath #(.DW(8), .AW(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .dp  (dp_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  // Model state
  logic [7:0] mm [16];
  logic [3:0] mpc;
  logic [7:0] macc, mb, mout, mir;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  task automatic sb_push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [7:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %h, scoreboard empty", tag, act);
    end else begin
      check(tag, act, exp_q.pop_front());
    end
  endtask

  // Assert the signals selected by mask; everything else idle.
  task automatic drive(input logic [11:0] mask);
    ctrl_t c;
    c = CTRL_IDLE ^ mask;
    dp_if.Cp = c.cp; dp_if.Ep = c.ep; dp_if.LM = c.lm; dp_if.CE = c.ce;
    dp_if.L1 = c.l1; dp_if.E1 = c.e1; dp_if.LA = c.la; dp_if.EA = c.ea;
    dp_if.SU = c.su; dp_if.EU = c.eu; dp_if.LB = c.lb; dp_if.LO = c.lo;
  endtask

  // One micro-step: control at negedge, loaded at posedge.
  task automatic uop(input logic [11:0] mask);
    @(negedge CLK);
    drive(mask);
    @(posedge CLK);
    #1;
  endtask

  // Drive-only step, bus observed before the next edge.
  task automatic probe(input logic [11:0] mask, input string tag);
    @(negedge CLK);
    drive(mask);
    #1;
    sb_check(tag, dp_if.wbus);
  endtask

  task automatic prog(input logic [3:0] addr, input logic [7:0] data);
    @(negedge CLK);
    drive('0);
    dp_if.prog_we   = 1'b1;
    dp_if.prog_addr = addr;
    dp_if.prog_data = data;
    @(posedge CLK);
    #1;
    dp_if.prog_we = 1'b0;
    mm[addr] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic done;
    logic [7:0] prog_img [8];
    logic [3:0] prog_adr [8];
    prog_adr = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB};
    prog_img = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h10, 8'h14, 8'h04};

    CLR = 1'b0;
    drive('0);
    dp_if.prog_we   = 1'b0;
    dp_if.prog_addr = '0;
    dp_if.prog_data = '0;
    #1;
    check("reset opcode",   {4'h0, dp_if.opcode}, 8'h00);
    check("reset halt",     {7'h0, dp_if.halt},   8'h00);
    check("reset out_data", dp_if.out_data,       8'h00);
    check("reset wbus",     dp_if.wbus,           8'h00);
`ifdef SAP1_BUS_CHECK_EN
    check("reset bus_err",  {7'h0, dp_if.bus_err}, 8'h00);
`endif
    repeat (2) @(negedge CLK);
    CLR = 1'b1;

    // ---------------- program and run ----------------
    for (int i = 0; i < 8; i++) prog(prog_adr[i], prog_img[i]);

    mpc = '0; macc = '0; mb = '0; mout = '0;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      uop(M_EP | M_LM);
      uop(M_CP);
      uop(M_CE | M_L1);
      mir = mm[mpc];
      mpc = mpc + 4'd1;
      sb_push({4'h0, mir[7:4]});
      sb_check("fetch opcode", {4'h0, dp_if.opcode});
      case (dp_if.opcode)
        OP_LDA: begin
          uop(M_E1 | M_LM); uop(M_CE | M_LA); uop('0);
          macc = mm[mir[3:0]];
          sb_push(macc);
          probe(M_EA, "A after LDA");
        end
        OP_ADD, OP_SUB: begin
          uop(M_E1 | M_LM); uop(M_CE | M_LB);
          uop(M_EU | M_LA | ((dp_if.opcode == OP_SUB) ? M_SU : 12'h000));
          mb   = mm[mir[3:0]];
          macc = (mir[7:4] == OP_SUB) ? macc - mb : macc + mb;
          sb_push(macc);
          probe(M_EA, "A after ADD/SUB");
        end
        OP_OUT: begin
          uop(M_EA | M_LO); uop('0); uop('0);
          mout = macc;
          sb_push(mout);
          sb_check("out_data after OUT", dp_if.out_data);
        end
        default: begin
          done = 1'b1;
          sb_push(8'h01);
          sb_check("halt after HLT", {7'h0, dp_if.halt});
        end
      endcase
    end
    if (!done) begin
      n_checks++;
      $display("FAIL run: no halt within 8 instructions, got opcode %h", dp_if.opcode);
    end
    check("program result", dp_if.out_data, 8'h20);

    // ---------------- halt freeze ----------------
    uop(M_CP | M_EP | M_LM | M_L1 | M_LA | M_LB | M_LO);
    prog(4'hC, 8'h5A);
    sb_push({4'h0, mpc});
    probe(M_EP, "halt PC frozen");
    sb_push(macc);
    probe(M_EA, "halt A frozen");
    sb_push(mout);
    sb_check("halt OUT frozen", dp_if.out_data);
    sb_push(8'h01);
    sb_check("halt held", {7'h0, dp_if.halt});

    // ---------------- CLR mid-execute ----------------
    @(negedge CLK);
    drive(M_CE | M_L1);
    #2 CLR = 1'b0;
    #1;
    check("clr opcode",   {4'h0, dp_if.opcode}, 8'h00);
    check("clr halt",     {7'h0, dp_if.halt},   8'h00);
    check("clr out_data", dp_if.out_data,       8'h00);
    check("clr wbus",     dp_if.wbus,           8'h00);
    drive('0);
    #1 CLR = 1'b1;
    mpc = '0; macc = '0;
    sb_push(mm[0]);
    probe(M_CE, "RAM[0] kept across CLR");
    sb_push(8'h00);
    probe(M_EA, "A cleared");

    // ---------------- write during halt, same-cycle read/write ----------------
    for (int i = 0; i < 12; i++) begin
      uop(M_CP);
      mpc = mpc + 4'd1;
    end
    uop(M_EP | M_LM);
    sb_push(mm[4'hC]);
    probe(M_CE, "RAM[C] written while halted");
    @(negedge CLK);
    drive(M_CE);
    dp_if.prog_we   = 1'b1;
    dp_if.prog_addr = 4'hC;
    dp_if.prog_data = 8'h77;
    sb_push(mm[4'hC]);
    #1 sb_check("read old data during write", dp_if.wbus);
    @(posedge CLK);
    #1;
    dp_if.prog_we = 1'b0;
    mm[4'hC] = 8'h77;
    sb_push(mm[4'hC]);
    sb_check("read new data after write", dp_if.wbus);

    // ---------------- PC wrap ----------------
    for (int i = 0; i < 3; i++) begin
      uop(M_CP);
      mpc = mpc + 4'd1;
    end
    sb_push({4'h0, mpc});
    probe(M_EP, "PC at 15");
    uop(M_CP);
    mpc = mpc + 4'd1;
    sb_push({4'h0, mpc});
    probe(M_EP, "PC wrapped");

    // ---------------- SUB underflow ----------------
    prog(4'h0, 8'h03);
    prog(4'h1, 8'h05);
    uop(M_EP | M_LM); uop(M_CE | M_LA); macc = mm[0];
    uop(M_CP);        mpc = mpc + 4'd1;
    uop(M_EP | M_LM); uop(M_CE | M_LB); mb = mm[1];
    sb_push(macc - mb);
    probe(M_EU | M_SU, "ALU A-B on bus");
    uop(M_EU | M_SU | M_LA);
    macc = macc - mb;
    sb_push(macc);
    probe(M_EA, "A after underflow");
    check("underflow value", dp_if.wbus, 8'hFE);
    sb_push(8'h00);
    probe('0, "idle bus");

    // ---------------- priority and bus check ----------------
`ifdef SAP1_BUS_CHECK_EN
    check("bus_err before contention", {7'h0, dp_if.bus_err}, 8'h00);
`endif
    sb_push({4'h0, mpc});
    probe(M_EP | M_CE, "Ep beats CE");
    @(posedge CLK);
    #1;
`ifdef SAP1_BUS_CHECK_EN
    check("bus_err set", {7'h0, dp_if.bus_err}, 8'h01);
`endif
    sb_push(8'h00);
    probe(M_E1 | M_EA, "E1 beats EA");
    uop('0);
`ifdef SAP1_BUS_CHECK_EN
    check("bus_err sticky", {7'h0, dp_if.bus_err}, 8'h01);
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    check("bus_err cleared", {7'h0, dp_if.bus_err}, 8'h00);
    CLR = 1'b1;
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
